// File: rtl/bip2_pkg.sv
// Shared definitions for the BIP2 data-memory bootloader: loader FSM states and
// stream framing constants.
package bip2_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ADDR_HI = 4'd1,
      ST_ADDR_LO = 4'd2,
      ST_CNT_HI  = 4'd3,
      ST_CNT_LO  = 4'd4,
      ST_DATA_HI = 4'd5,
      ST_DATA_LO = 4'd6,
      ST_WRITE   = 4'd7,
      ST_FINISH  = 4'd8
   } loader_state_t;

   localparam int HDR_BYTES      = 4;
   localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/byte_pair_assembler.sv
// Joins a big-endian hi/lo byte pair into one field; the lo byte is used live so the
// assembled value and its valid strobe appear in the same cycle the lo byte is accepted.
module byte_pair_assembler #(
   parameter int OUT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_hi,
   input  logic             load_lo,
   input  logic [7:0]       byte_in,
   output logic [OUT_W-1:0] value,
   output logic             valid
);

   // Only the hi-byte bits that survive truncation to OUT_W are stored (OUT_W in 9..16).
   localparam int HI_W = OUT_W - 8;

   logic [HI_W-1:0] hi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
      end else if (load_hi) begin
         hi_q <= byte_in[HI_W-1:0];
      end
   end

   assign value = {hi_q, byte_in};
   assign valid = load_lo;

endmodule

// File: rtl/dm_loader.sv
// Serial bootloader in front of the BIP2 data memory: parses start/count/data bytes,
// writes one word per WRITE cycle, and passes CPU accesses through while idle.
module dm_loader
   import bip2_pkg::*;
#(
   parameter int WORD_WIDTH = 11,
   parameter int ADDR_WIDTH = 11,
   parameter int MEM_SIZE   = 1023
) (
   input  logic                  CLK_i,
   input  logic                  RST_i,
   input  logic                  START_i,
   input  logic [7:0]            RX_DATA_i,
   input  logic                  RX_VALID_i,
   output logic                  RX_READY_o,
   input  logic                  CPU_WR_i,
   input  logic [ADDR_WIDTH-1:0] CPU_ADDR_i,
   input  logic [WORD_WIDTH-1:0] CPU_DATA_i,
   output logic                  WR_o,
   output logic [ADDR_WIDTH-1:0] ADDR_o,
   output logic [WORD_WIDTH-1:0] DATA_o,
   output logic                  BUSY_o,
   output logic                  DONE_o,
   output logic                  ERR_o,
   output loader_state_t         dbg_state
);

   localparam logic [ADDR_WIDTH-1:0] MEM_LAST = ADDR_WIDTH'(MEM_SIZE);

   // Stream handshake: a byte moves on a cycle where RX_VALID_i and RX_READY_o are both
   // high; RX_READY_o depends on state only, and a non-ready byte stays with the sender.
   loader_state_t state, next_state;

   logic [ADDR_WIDTH-1:0] addr_q, cnt_q, addr_in, cnt_in;
   logic [WORD_WIDTH-1:0] data_q, data_in;
   logic                  err_q, accept, addr_vld, cnt_vld, data_vld;

   assign RX_READY_o = (state inside {ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI,
                                      ST_CNT_LO, ST_DATA_HI, ST_DATA_LO});
   assign accept     = RX_VALID_i && RX_READY_o;
   assign ERR_o      = err_q;
   assign dbg_state  = state;

   byte_pair_assembler #(.OUT_W(ADDR_WIDTH)) u_addr (
      .clk(CLK_i), .rst(RST_i),
      .load_hi(accept && state == ST_ADDR_HI), .load_lo(accept && state == ST_ADDR_LO),
      .byte_in(RX_DATA_i), .value(addr_in), .valid(addr_vld)
   );

   byte_pair_assembler #(.OUT_W(ADDR_WIDTH)) u_cnt (
      .clk(CLK_i), .rst(RST_i),
      .load_hi(accept && state == ST_CNT_HI), .load_lo(accept && state == ST_CNT_LO),
      .byte_in(RX_DATA_i), .value(cnt_in), .valid(cnt_vld)
   );

   byte_pair_assembler #(.OUT_W(WORD_WIDTH)) u_data (
      .clk(CLK_i), .rst(RST_i),
      .load_hi(accept && state == ST_DATA_HI), .load_lo(accept && state == ST_DATA_LO),
      .byte_in(RX_DATA_i), .value(data_in), .valid(data_vld)
   );

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      BUSY_o     = 1'b1;
      DONE_o     = 1'b0;
      WR_o       = 1'b0;
      ADDR_o     = addr_q;
      DATA_o     = data_q;
      case (state)
         ST_IDLE: begin
            BUSY_o = 1'b0;
            WR_o   = CPU_WR_i;
            ADDR_o = CPU_ADDR_i;
            DATA_o = CPU_DATA_i;
            if (START_i) next_state = ST_ADDR_HI;
         end
         ST_ADDR_HI: if (accept) next_state = ST_ADDR_LO;
         ST_ADDR_LO: if (accept) next_state = ST_CNT_HI;
         ST_CNT_HI:  if (accept) next_state = ST_CNT_LO;
         ST_CNT_LO: begin
            if (cnt_vld) begin
               if (addr_q > MEM_LAST)  next_state = ST_IDLE;
               else if (cnt_in == '0)  next_state = ST_FINISH;
               else                    next_state = ST_DATA_HI;
            end
         end
         ST_DATA_HI: if (accept) next_state = ST_DATA_LO;
         ST_DATA_LO: if (data_vld) next_state = ST_WRITE;
         ST_WRITE: begin
            WR_o       = 1'b1;
            next_state = (cnt_q == ADDR_WIDTH'(1)) ? ST_FINISH : ST_DATA_HI;
         end
         ST_FINISH: begin
            DONE_o     = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         addr_q <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == ST_IDLE && START_i) err_q <= 1'b0;
         if (cnt_vld && addr_q > MEM_LAST) err_q <= 1'b1;
         if (addr_vld) addr_q <= addr_in;
         if (cnt_vld)  cnt_q  <= cnt_in;
         if (data_vld) data_q <= data_in;
         // Long counts deliberately wrap and overwrite from address 0.
         if (state == ST_WRITE) begin
            addr_q <= (addr_q == MEM_LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
            cnt_q  <= cnt_q - ADDR_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_dm_loader.sv
// Directed bench for dm_loader: pass-through, loads, wrap, zero count, error,
// backpressure with stray START, and reset mid-load.
module tb_dm_loader;
   import bip2_pkg::*;

   localparam int AW = 11;
   localparam int WW = 11;

   logic          clk = 1'b0;
   logic          RST_i = 1'b1, START_i = 1'b0, RX_VALID_i = 1'b0, CPU_WR_i = 1'b0;
   logic [7:0]    RX_DATA_i = '0;
   logic [AW-1:0] CPU_ADDR_i = '0, ADDR_o;
   logic [WW-1:0] CPU_DATA_i = '0, DATA_o;
   logic          RX_READY_o, WR_o, BUSY_o, DONE_o, ERR_o;
   loader_state_t dbg_state;

   int total = 0, bad = 0, wr_seen = 0, done_seen = 0, cyc = 0;
   int t0 = 0, done_at = 0, wr_base = 0, done_base = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  byte_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   dm_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MEM_SIZE(1023)) dut (
      .CLK_i(clk), .RST_i(RST_i), .START_i(START_i),
      .RX_DATA_i(RX_DATA_i), .RX_VALID_i(RX_VALID_i), .RX_READY_o(RX_READY_o),
      .CPU_WR_i(CPU_WR_i), .CPU_ADDR_i(CPU_ADDR_i), .CPU_DATA_i(CPU_DATA_i),
      .WR_o(WR_o), .ADDR_o(ADDR_o), .DATA_o(DATA_o),
      .BUSY_o(BUSY_o), .DONE_o(DONE_o), .ERR_o(ERR_o), .dbg_state(dbg_state)
   );

   function automatic logic [31:0] pack(input logic [AW-1:0] a, input logic [WW-1:0] d);
      return {10'b0, a, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every loader write (busy and WR_o) must match the next expected word.
   always begin
      @(negedge clk);
      #2;
      if (DONE_o) done_seen++;
      if (BUSY_o && WR_o) begin
         wr_seen++;
         if (exp_q.size() > 0) check("write_word", pack(ADDR_o, DATA_o), exp_q.pop_front());
      end
   end

   task automatic push_bytes(input logic [15:0] a, input logic [15:0] n);
      byte_q.push_back(a[15:8]); byte_q.push_back(a[7:0]);
      byte_q.push_back(n[15:8]); byte_q.push_back(n[7:0]);
   endtask

   task automatic push_word(input logic [15:0] w);
      byte_q.push_back(w[15:8]); byte_q.push_back(w[7:0]);
   endtask

   task automatic start_load();
      @(negedge clk);
      START_i   = 1'b1;
      t0        = cyc;
      wr_base   = wr_seen;
      done_base = done_seen;
   endtask

   task automatic send_stream(input bit jitter, input bit poke_start);
      logic [7:0] b;
      int  waited;
      bit  took;
      while (byte_q.size() > 0) begin
         b      = byte_q.pop_front();
         waited = 0;
         took   = 1'b0;
         while (!took && waited < 40) begin
            @(negedge clk);
            RX_DATA_i  = b;
            RX_VALID_i = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            START_i    = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            took   = RX_VALID_i && RX_READY_o;
            waited++;
         end
         if (!took) check("byte_accept", {31'b0, took}, 32'd1);
      end
      @(negedge clk);
      RX_VALID_i = 1'b0;
      START_i    = 1'b0;
   endtask

   task automatic wait_done(output int at);
      int n;
      at = -1;
      n  = 0;
      while (at < 0 && n < 20) begin
         #1;
         if (DONE_o) at = cyc;
         else @(negedge clk);
         n++;
      end
   endtask

   task automatic basic_load(input bit jitter, input bit poke_start);
      push_bytes(16'h0010, 16'h0003);
      push_word(16'h0001); push_word(16'h0002); push_word(16'h07FF);
      exp_q.push_back(pack(11'h010, 11'h001));
      exp_q.push_back(pack(11'h011, 11'h002));
      exp_q.push_back(pack(11'h012, 11'h7FF));
      start_load();
      send_stream(jitter, poke_start);
      wait_done(done_at);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with CPU driving a write: outputs must follow the CPU.
      CPU_WR_i = 1'b1; CPU_ADDR_i = 11'h123; CPU_DATA_i = 11'h456;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", {31'b0, BUSY_o}, 32'd0);
      check("rst_ready", {31'b0, RX_READY_o}, 32'd0);
      check("rst_done", {31'b0, DONE_o}, 32'd0);
      check("rst_err", {31'b0, ERR_o}, 32'd0);
      check("rst_state", {28'b0, dbg_state}, {28'b0, ST_IDLE});
      check("rst_pass", pack(ADDR_o, DATA_o), pack(11'h123, 11'h456));
      @(negedge clk);
      RST_i = 1'b0;

      // Pass-through while idle.
      CPU_WR_i = 1'b1; CPU_ADDR_i = 11'd5; CPU_DATA_i = 11'h02A;
      #1;
      check("pass_wr", {31'b0, WR_o}, 32'd1);
      check("pass_word", pack(ADDR_o, DATA_o), pack(11'd5, 11'h02A));
      @(negedge clk);
      CPU_WR_i = 1'b0; CPU_ADDR_i = 11'h7FF;
      #1;
      check("pass_wr_low", {31'b0, WR_o}, 32'd0);
      check("pass_addr2", {21'b0, ADDR_o}, 32'h7FF);

      // Basic load with the CPU trying to write throughout; min latency 1+4+3*3.
      CPU_WR_i = 1'b1; CPU_ADDR_i = 11'd7; CPU_DATA_i = 11'h055;
      basic_load(1'b0, 1'b0);
      check("basic_latency", done_at - t0, 1 + HDR_BYTES + (BYTES_PER_WORD + 1) * 3);
      check("basic_busy_finish", {31'b0, BUSY_o}, 32'd1);
      @(negedge clk);
      #1;
      check("basic_busy_after", {31'b0, BUSY_o}, 32'd0);
      check("basic_pass_after", pack(ADDR_o, DATA_o), pack(11'd7, 11'h055));
      check("basic_writes", wr_seen - wr_base, 3);
      check("basic_dones", done_seen - done_base, 1);
      CPU_WR_i = 1'b0;

      // Start at the last word: second write wraps to address 0.
      push_bytes(16'h03FF, 16'h0002);
      push_word(16'h000A); push_word(16'h000B);
      exp_q.push_back(pack(11'h3FF, 11'h00A));
      exp_q.push_back(pack(11'h000, 11'h00B));
      start_load();
      send_stream(1'b0, 1'b0);
      wait_done(done_at);
      check("wrap_latency", done_at - t0, 1 + 4 + 3 * 2);
      @(negedge clk);
      check("wrap_writes", wr_seen - wr_base, 2);

      // Bad start address aborts: ERR, idle at once, no write, no DONE.
      push_bytes(16'h0500, 16'h0001);
      start_load();
      send_stream(1'b0, 1'b0);
      #1;
      check("err_set", {31'b0, ERR_o}, 32'd1);
      check("err_busy", {31'b0, BUSY_o}, 32'd0);
      repeat (6) @(negedge clk);
      #1;
      check("err_sticky", {31'b0, ERR_o}, 32'd1);
      check("err_writes", wr_seen - wr_base, 0);
      check("err_dones", done_seen - done_base, 0);

      // Zero count: START clears ERR, DONE with no write.
      push_bytes(16'h0020, 16'h0000);
      start_load();
      send_stream(1'b0, 1'b0);
      wait_done(done_at);
      check("zero_latency", done_at - t0, 1 + 4);
      check("zero_err_clear", {31'b0, ERR_o}, 32'd0);
      @(negedge clk);
      check("zero_writes", wr_seen - wr_base, 0);
      check("zero_dones", done_seen - done_base, 1);

      // Random valid gaps, stray START pulses and CPU writes: same result as basic.
      CPU_WR_i = 1'b1; CPU_ADDR_i = 11'd9; CPU_DATA_i = 11'h3C3;
      basic_load(1'b1, 1'b1);
      check("jit_done_seen", {31'b0, done_at > t0}, 32'd1);
      @(negedge clk);
      CPU_WR_i = 1'b0;
      check("jit_writes", wr_seen - wr_base, 3);
      check("jit_dones", done_seen - done_base, 1);
      check("jit_queue", exp_q.size(), 0);

      // Reset after the first of three words.
      push_bytes(16'h0010, 16'h0003);
      push_word(16'h0001);
      byte_q.push_back(8'h00);
      exp_q.push_back(pack(11'h010, 11'h001));
      start_load();
      send_stream(1'b0, 1'b0);
      RST_i = 1'b1; RX_VALID_i = 1'b1; RX_DATA_i = 8'h02; CPU_ADDR_i = 11'h0AA;
      @(negedge clk);
      #1;
      check("mid_rst_busy", {31'b0, BUSY_o}, 32'd0);
      check("mid_rst_ready", {31'b0, RX_READY_o}, 32'd0);
      check("mid_rst_wr", {31'b0, WR_o}, 32'd0);
      check("mid_rst_addr", {21'b0, ADDR_o}, 32'h0AA);
      RST_i = 1'b0;
      repeat (8) @(negedge clk);
      RX_VALID_i = 1'b0;
      check("mid_rst_writes", wr_seen - wr_base, 1);
      check("mid_rst_dones", done_seen - done_base, 0);

      // Clean load afterwards.
      push_bytes(16'h0100, 16'h0001);
      push_word(16'h0123);
      exp_q.push_back(pack(11'h100, 11'h123));
      start_load();
      send_stream(1'b0, 1'b0);
      wait_done(done_at);
      check("post_rst_latency", done_at - t0, 1 + 4 + 3);
      @(negedge clk);
      check("post_rst_writes", wr_seen - wr_base, 1);
      check("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
